// File: rtl/bram12_arbiter.sv
// bram12_arbiter: shares the single port of the FIR's 12-word tap/data BRAM
// between the host configuration path and the FIR engine.
// Latency: grant and BRAM drive are combinational in the request cycle.
// Read data returns exactly one cycle after the read grant.
// Backpressure: requests use valid/ready, with at most one grant per cycle.
// Responses are never stalled.
//
// Ports:
//   CLK, RST                   clock (rising edge), async active-high reset
//   h_req_* / h_rsp_*          host request (valid/ready/we/addr/wdata) and read response
//   e_req_* / e_rsp_*, e_lock  engine request, read response, sweep lock
//   bram_EN/WE/Di/A, bram_Do   BRAM port A; Do is combinational from the BRAM's registered address
module bram12_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 12
) (
  input  logic              CLK,
  input  logic              RST,
  // host requester
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic [3:0]        h_req_we,
  input  logic [ADDR_W-1:0] h_req_addr,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rsp_rdata,
  // engine requester
  input  logic              e_req_valid,
  output logic              e_req_ready,
  input  logic [3:0]        e_req_we,
  input  logic [ADDR_W-1:0] e_req_addr,
  input  logic [DATA_W-1:0] e_req_wdata,
  input  logic              e_lock,
  output logic              e_rsp_valid,
  output logic [DATA_W-1:0] e_rsp_rdata,
  // BRAM port A
  output logic              bram_EN,
  output logic [3:0]        bram_WE,
  output logic [DATA_W-1:0] bram_Di,
  output logic [ADDR_W-1:0] bram_A,
  input  logic [DATA_W-1:0] bram_Do
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam logic [WORD_AW-1:0] NUM_WORDS_W = WORD_AW'(NUM_WORDS);

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_ENG  = 1'b1
  } gnt_e;

  gnt_e last_gnt_q, last_gnt_d;

  // Pending read response: who asked, and whether it was out of range.
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_eng_q,  rsp_eng_d;
  logic rsp_oob_q,  rsp_oob_d;

  logic gnt_h, gnt_e_s, any_gnt;
  logic h_oob, e_oob, sel_oob;
  logic [3:0] sel_we;
  logic [DATA_W-1:0] rsp_data;

  // Byte addresses past the last word are accepted but never touch the array.
  assign h_oob = (h_req_addr[ADDR_W-1:2] >= NUM_WORDS_W);
  assign e_oob = (e_req_addr[ADDR_W-1:2] >= NUM_WORDS_W);

  // Arbitration. The lock only holds priority once the engine already owns
  // the last grant, so a lock raised while the host won last has to wait
  // for one ordinary round-robin engine win.
  always_comb begin
    gnt_h   = 1'b0;
    gnt_e_s = 1'b0;
    if (!RST) begin
      if (e_lock && (last_gnt_q == GNT_ENG) && e_req_valid) begin
        gnt_e_s = 1'b1;
      end else if (h_req_valid && e_req_valid) begin
        if (last_gnt_q == GNT_ENG) gnt_h   = 1'b1;
        else                       gnt_e_s = 1'b1;
      end else if (h_req_valid) begin
        gnt_h = 1'b1;
      end else if (e_req_valid) begin
        gnt_e_s = 1'b1;
      end
    end
  end

  assign any_gnt     = gnt_h | gnt_e_s;
  assign h_req_ready = gnt_h;
  assign e_req_ready = gnt_e_s;

  // Without a grant the host payload sits on the bus; WE is 0 so it is inert.
  assign sel_we  = gnt_e_s ? e_req_we : h_req_we;
  assign sel_oob = gnt_e_s ? e_oob    : h_oob;
  assign bram_A  = gnt_e_s ? e_req_addr  : h_req_addr;
  assign bram_Di = gnt_e_s ? e_req_wdata : h_req_wdata;
  assign bram_WE = (any_gnt && !sel_oob) ? sel_we : 4'b0000;

  // The BRAM gates Do with EN, so EN must also cover the response cycle.
  assign bram_EN = any_gnt | rsp_pend_q;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_e_s)    last_gnt_d = GNT_ENG;
    else if (gnt_h) last_gnt_d = GNT_HOST;
    rsp_pend_d = any_gnt && (sel_we == 4'b0000);
    rsp_eng_d  = gnt_e_s;
    rsp_oob_d  = sel_oob;
  end

  // Async reset also drops any response that was in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_gnt_q <= GNT_ENG;
      rsp_pend_q <= 1'b0;
      rsp_eng_q  <= 1'b0;
      rsp_oob_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_eng_q  <= rsp_eng_d;
      rsp_oob_q  <= rsp_oob_d;
    end
  end

  // Out-of-range reads return zero rather than whatever the BRAM aliases to.
  assign rsp_data = rsp_oob_q ? '0 : bram_Do;

  assign h_rsp_valid = rsp_pend_q & ~rsp_eng_q;
  assign e_rsp_valid = rsp_pend_q &  rsp_eng_q;
  assign h_rsp_rdata = h_rsp_valid ? rsp_data : '0;
  assign e_rsp_rdata = e_rsp_valid ? rsp_data : '0;

endmodule

// File: tb/tb_bram12_arbiter.sv
// Bench for bram12_arbiter. A BRAM model with a registered address and an
// EN-masked Do is attached. A spec-level model runs in a per-cycle compare
// process, and the directed vectors add hand-computed literal checks.
module tb_bram12_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        h_req_valid = 1'b0, e_req_valid = 1'b0, e_lock = 1'b0;
  logic [3:0]  h_req_we = 4'h0, e_req_we = 4'h0;
  logic [11:0] h_req_addr = '0, e_req_addr = '0;
  logic [31:0] h_req_wdata = '0, e_req_wdata = '0;
  logic        h_req_ready, e_req_ready, h_rsp_valid, e_rsp_valid;
  logic [31:0] h_rsp_rdata, e_rsp_rdata;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_Di, bram_Do;
  logic [11:0] bram_A;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bram12_arbiter #(.ADDR_W(12), .DATA_W(32), .NUM_WORDS(12)) dut (
    .CLK(CLK), .RST(RST),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
    .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
    .h_rsp_valid(h_rsp_valid), .h_rsp_rdata(h_rsp_rdata),
    .e_req_valid(e_req_valid), .e_req_ready(e_req_ready), .e_req_we(e_req_we),
    .e_req_addr(e_req_addr), .e_req_wdata(e_req_wdata), .e_lock(e_lock),
    .e_rsp_valid(e_rsp_valid), .e_rsp_rdata(e_rsp_rdata),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_Di(bram_Di),
    .bram_A(bram_A), .bram_Do(bram_Do)
  );

  // BRAM: 16 physical words. Words 12..15 hold a marker so an unmasked
  // out-of-range read would be visible.
  logic [31:0] bmem [16];
  logic [11:0] a_q = '0;
  always @(posedge CLK) begin
    if (bram_EN) begin
      for (int b = 0; b < 4; b++)
        if (bram_WE[b]) bmem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
      a_q <= bram_A;
    end
  end
  assign bram_Do = bram_EN ? bmem[a_q[5:2]] : 32'h0;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0005A00 | (32'(i) << 16) | 32'(i);
  endfunction

  logic [31:0] ref_mem [12];
  initial begin
    for (int i = 0; i < 16; i++) bmem[i] = (i < 12) ? init_val(i) : 32'hBAD0BAD0;
    for (int i = 0; i < 12; i++) ref_mem[i] = init_val(i);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Spec-level model: who should win, what the BRAM should see, and what each
  // requester should receive next cycle. 0 = none, 1 = host, 2 = engine.
  int          m_last;
  bit          m_pend;
  int          m_pid;
  logic [31:0] m_pdata;
  int          g, word;
  bit          oob;
  logic [3:0]  we;
  logic [11:0] addr;
  logic [31:0] wd;
  initial begin
    m_last = 2; m_pend = 0; m_pid = 0; m_pdata = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("rst_h_ready", h_req_ready, 0);
        chk("rst_e_ready", e_req_ready, 0);
        chk("rst_h_rsp_valid", h_rsp_valid, 0);
        chk("rst_e_rsp_valid", e_rsp_valid, 0);
        chk("rst_bram_EN", bram_EN, 0);
        chk("rst_bram_WE", bram_WE, 0);
        chk("rst_h_rdata", h_rsp_rdata, 0);
        chk("rst_e_rdata", e_rsp_rdata, 0);
        m_last = 2; m_pend = 0;
      end else begin
        if (e_lock && m_last == 2 && e_req_valid) g = 2;
        else if (h_req_valid && e_req_valid)      g = (m_last == 1) ? 2 : 1;
        else if (h_req_valid)                     g = 1;
        else if (e_req_valid)                     g = 2;
        else                                      g = 0;

        chk("h_ready", h_req_ready, (g == 1));
        chk("e_ready", e_req_ready, (g == 2));
        chk("bram_EN", bram_EN, (g != 0) || m_pend);
        chk("h_rsp_valid", h_rsp_valid, m_pend && m_pid == 1);
        chk("e_rsp_valid", e_rsp_valid, m_pend && m_pid == 2);
        if (m_pend && m_pid == 1) chk("h_rsp_rdata", h_rsp_rdata, m_pdata);
        if (m_pend && m_pid == 2) chk("e_rsp_rdata", e_rsp_rdata, m_pdata);

        m_pend = 0;
        if (g == 0) begin
          chk("idle_bram_WE", bram_WE, 0);
        end else begin
          we   = (g == 1) ? h_req_we    : e_req_we;
          addr = (g == 1) ? h_req_addr  : e_req_addr;
          wd   = (g == 1) ? h_req_wdata : e_req_wdata;
          word = int'(addr) / 4;
          oob  = (word >= 12);
          chk("bram_A", bram_A, addr);
          chk("bram_WE", bram_WE, oob ? 4'h0 : we);
          if (!oob && we != 0) chk("bram_Di", bram_Di, wd);
          m_last = g;
          if (we == 0) begin
            m_pend = 1; m_pid = g;
            m_pdata = oob ? 32'h0 : ref_mem[word];
          end else if (!oob) begin
            for (int b = 0; b < 4; b++)
              if (we[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_h(input logic v, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
    h_req_valid = v; h_req_we = w; h_req_addr = a; h_req_wdata = d;
  endtask

  task automatic set_e(input logic v, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
    e_req_valid = v; e_req_we = w; e_req_addr = a; e_req_wdata = d;
  endtask

  initial begin
    // Reset with both requesting: nothing may be granted.
    set_h(1, 4'h0, 12'h000, 0);
    set_e(1, 4'h0, 12'h004, 0);
    repeat (3) tick();
    set_h(0, 0, 0, 0); set_e(0, 0, 0, 0);
    RST = 1'b0;

    // Host write then read-back of word 2.
    set_h(1, 4'hF, 12'h008, 32'hDEADBEEF);
    @(negedge CLK); chk("t1_wr_ready", h_req_ready, 1); chk("t1_wr_we", bram_WE, 4'hF);
    tick(); set_h(1, 4'h0, 12'h008, 0);
    @(negedge CLK); chk("t1_rd_ready", h_req_ready, 1);
    tick(); set_h(0, 0, 0, 0);
    @(negedge CLK);
    chk("t1_rsp_valid", h_rsp_valid, 1);
    chk("t1_rsp_data", h_rsp_rdata, 32'hDEADBEEF);
    chk("t1_e_rsp_quiet", e_rsp_valid, 0);
    tick();

    // Engine read so the engine owns the last grant, then contention.
    set_e(1, 4'h0, 12'h02C, 0);
    tick(); set_e(0, 0, 0, 0);
    tick();
    set_h(1, 4'h0, 12'h000, 0);
    set_e(1, 4'h0, 12'h004, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("t2_h_ready", h_req_ready, (c % 2 == 0));
      chk("t2_e_ready", e_req_ready, (c % 2 == 1));
      if (c % 2 == 1) chk("t2_h_data", h_rsp_rdata, 32'hC0005A00);
      if (c > 0 && c % 2 == 0) chk("t2_e_data", e_rsp_rdata, 32'hC0015A01);
      tick();
    end
    set_h(0, 0, 0, 0); set_e(0, 0, 0, 0);
    @(negedge CLK);
    chk("t2_last_e_valid", e_rsp_valid, 1);
    chk("t2_last_e_data", e_rsp_rdata, 32'hC0015A01);
    tick();

    // Engine lock sweep over words 0..10 while the host keeps asking.
    e_lock = 1'b1;
    set_h(1, 4'h0, 12'h000, 0);
    for (int i = 0; i < 11; i++) begin
      set_e(1, 4'h0, 12'(i * 4), 0);
      @(negedge CLK);
      chk("t3_lock_e_ready", e_req_ready, 1);
      chk("t3_lock_h_ready", h_req_ready, 0);
      tick();
    end
    e_lock = 1'b0;
    set_e(1, 4'h0, 12'h02C, 0);
    @(negedge CLK); chk("t3_unlock_h_ready", h_req_ready, 1); chk("t3_unlock_e_ready", e_req_ready, 0);
    tick(); set_h(0, 0, 0, 0);
    @(negedge CLK); chk("t3_e_after", e_req_ready, 1);
    tick(); set_e(0, 0, 0, 0);
    tick();

    // Byte-lane write into word 3.
    set_h(1, 4'hF, 12'h00C, 32'h11223344);
    tick(); set_h(0, 0, 0, 0);
    set_e(1, 4'b0101, 12'h00C, 32'hAABBCCDD);
    @(negedge CLK); chk("t4_lane_we", bram_WE, 4'b0101);
    tick(); set_e(0, 0, 0, 0);
    set_h(1, 4'h0, 12'h00C, 0);
    tick(); set_h(0, 0, 0, 0);
    @(negedge CLK); chk("t4_lane_valid", h_rsp_valid, 1); chk("t4_lane_data", h_rsp_rdata, 32'h11BB33DD);
    tick();

    // Out of range write and read.
    set_h(1, 4'hF, 12'h030, 32'hFFFFFFFF);
    @(negedge CLK);
    chk("t5_oob_ready", h_req_ready, 1);
    chk("t5_oob_we", bram_WE, 4'h0);
    chk("t5_oob_en", bram_EN, 1);
    tick(); set_h(1, 4'h0, 12'h030, 0);
    tick(); set_h(0, 0, 0, 0);
    @(negedge CLK); chk("t5_oob_rsp_valid", h_rsp_valid, 1); chk("t5_oob_rsp_data", h_rsp_rdata, 32'h0);
    chk("t5_oob_mem12", bmem[12], 32'hBAD0BAD0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_e(1, 4'h0, 12'(i * 4), 0);
      tick();
    end
    set_e(0, 0, 0, 0);
    @(negedge CLK); chk("t5_sweep_last", e_rsp_rdata, init_val(11));
    tick();

    // Reset right after a host read grant: the response must vanish.
    set_h(1, 4'h0, 12'h000, 0);
    @(negedge CLK); chk("t6_rd_ready", h_req_ready, 1);
    tick(); RST = 1'b1; set_h(0, 0, 0, 0);
    @(negedge CLK); chk("t6_rst_no_rsp", h_rsp_valid, 0); chk("t6_rst_en", bram_EN, 0);
    tick(); tick(); RST = 1'b0;
    @(negedge CLK); chk("t6_post_no_rsp", h_rsp_valid, 0);
    tick();
    set_h(1, 4'h0, 12'h004, 0);
    set_e(1, 4'h0, 12'h008, 0);
    @(negedge CLK); chk("t6_first_h", h_req_ready, 1); chk("t6_first_e", e_req_ready, 0);
    tick(); set_h(0, 0, 0, 0);
    tick(); set_e(0, 0, 0, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
